// File: rtl/exception_unit_if.sv
// Pipeline <-> exception sequencer bundle: requests and current special-register
// values in, rm write port and fetch redirect out.
interface exception_unit_if #(
  parameter int ARCH_BITS = 32
);
  logic [3:0]           excReq;
  logic [ARCH_BITS-1:0] excPc;
  logic [ARCH_BITS-1:0] excAddr;
  logic                 iretReq;
  logic [ARCH_BITS-1:0] curPriv;
  logic [ARCH_BITS-1:0] rmCur0;
  logic [ARCH_BITS-1:0] rmCur1;
  logic [ARCH_BITS-1:0] rmCur2;
  logic [ARCH_BITS-1:0] rm0wData;
  logic [ARCH_BITS-1:0] rm1wData;
  logic [ARCH_BITS-1:0] rm2wData;
  logic [ARCH_BITS-1:0] rm4wData;
  logic                 rmWriteEnable;
  logic                 flush;
  logic                 stall;
  logic [ARCH_BITS-1:0] pcRedirect;
  logic                 pcRedirectValid;
  logic                 busy;

  // pipeline / regfile side
  modport master (
    output excReq, excPc, excAddr, iretReq, curPriv, rmCur0, rmCur1, rmCur2,
    input  rm0wData, rm1wData, rm2wData, rm4wData, rmWriteEnable,
           flush, stall, pcRedirect, pcRedirectValid, busy
  );

  // exception sequencer side
  modport slave (
    input  excReq, excPc, excAddr, iretReq, curPriv, rmCur0, rmCur1, rmCur2,
    output rm0wData, rm1wData, rm2wData, rm4wData, rmWriteEnable,
           flush, stall, pcRedirect, pcRedirectValid, busy
  );
endinterface

// File: rtl/exception_unit.sv
// Exception / iret sequencer. Accepts one request in IDLE, flushes the pipe,
// waits for drain, writes rm0/rm1/rm2/rm4 in one shot, then redirects fetch.
module exception_unit #(
  parameter int                   ARCH_BITS     = 32,
  parameter logic [ARCH_BITS-1:0] EXC_VECTOR    = 32'h0000_2000,
  parameter logic [ARCH_BITS-1:0] PRIVILEGE_OS  = 32'd1,
  parameter logic [ARCH_BITS-1:0] PRIVILEGE_USR = 32'd0,
  parameter int                   DRAIN_CYCLES  = 3
) (
  input logic              clk,
  input logic              rst,
  exception_unit_if.slave  bus
);

  localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_FLUSH, S_DRAIN, S_COMMIT, S_REDIRECT
  } state_t;

  state_t                r_state, w_next;
  logic [CNT_W-1:0]      r_cnt;
  logic [ARCH_BITS-1:0]  r_rm0, r_rm1, r_rm2, r_rm4, r_redirect;

  logic [3:0]            w_mask;
  logic [1:0]            w_causeIdx;
  logic                  w_excHit;
  logic                  w_accept;
  logic                  w_flush, w_stall, w_we, w_redirV, w_busy;

  // External interrupts are not taken while already running in OS mode.
  assign w_mask   = bus.excReq & {bus.curPriv != PRIVILEGE_OS, 3'b111};
  assign w_excHit = |w_mask;
  assign w_accept = (r_state == S_IDLE) && (w_excHit || bus.iretReq);

  // Lowest set unmasked request bit wins (scan high to low, last hit sticks).
  always_comb begin
    w_causeIdx = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (w_mask[i]) w_causeIdx = 2'(i);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Drain down-counter: loaded on the way into DRAIN, counts to zero there.
  always_ff @(posedge clk) begin
    if (rst)                      r_cnt <= '0;
    else if (r_state == S_FLUSH)  r_cnt <= CNT_W'(DRAIN_CYCLES - 1);
    else if (r_state == S_DRAIN && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
  end

  // Latch the commit payload at accept; exception takes precedence over iret.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rm0      <= '0;
      r_rm1      <= '0;
      r_rm2      <= '0;
      r_rm4      <= '0;
      r_redirect <= '0;
    end else if (w_accept) begin
      if (w_excHit) begin
        r_rm0      <= bus.excPc;
        r_rm1      <= bus.excAddr;
        r_rm2      <= ARCH_BITS'(w_causeIdx);
        r_rm4      <= PRIVILEGE_OS;
        r_redirect <= EXC_VECTOR;
      end else begin
        r_rm0      <= bus.rmCur0;
        r_rm1      <= bus.rmCur1;
        r_rm2      <= bus.rmCur2;
        r_rm4      <= PRIVILEGE_USR;
        r_redirect <= bus.rmCur0;
      end
    end
  end

  // Next-state and per-state control outputs.
  always_comb begin
    w_next   = r_state;
    w_flush  = 1'b0;
    w_stall  = 1'b0;
    w_we     = 1'b0;
    w_redirV = 1'b0;
    w_busy   = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (w_accept) w_next = S_FLUSH;
      end
      S_FLUSH: begin
        w_flush = 1'b1;
        w_stall = 1'b1;
        w_next  = S_DRAIN;
      end
      S_DRAIN: begin
        w_stall = 1'b1;
        if (r_cnt == '0) w_next = S_COMMIT;
      end
      S_COMMIT: begin
        w_stall = 1'b1;
        w_we    = 1'b1;
        w_next  = S_REDIRECT;
      end
      S_REDIRECT: begin
        w_stall  = 1'b1;
        w_redirV = 1'b1;
        w_next   = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Everything reads as zero while reset is held, including the cycle it rises.
  assign bus.flush           = w_flush  & ~rst;
  assign bus.stall           = w_stall  & ~rst;
  assign bus.rmWriteEnable   = w_we     & ~rst;
  assign bus.pcRedirectValid = w_redirV & ~rst;
  assign bus.busy            = w_busy   & ~rst;
  assign bus.rm0wData        = rst ? '0 : r_rm0;
  assign bus.rm1wData        = rst ? '0 : r_rm1;
  assign bus.rm2wData        = rst ? '0 : r_rm2;
  assign bus.rm4wData        = rst ? '0 : r_rm4;
  assign bus.pcRedirect      = rst ? '0 : r_redirect;

endmodule

// File: tb/tb_exception_unit.sv
// Scoreboard bench for exception_unit: stimulus pushes expected commit and
// redirect events; a negedge monitor pops and compares whenever they appear.
module tb_exception_unit;

  localparam int D = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  exception_unit_if #(.ARCH_BITS(32)) bus();

  exception_unit #(
    .ARCH_BITS(32), .EXC_VECTOR(32'h0000_2000), .PRIVILEGE_OS(32'd1),
    .PRIVILEGE_USR(32'd0), .DRAIN_CYCLES(D)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          redir;
    int          cyc;
    logic [31:0] rm0, rm1, rm2, rm4, pc;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every output event must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.rmWriteEnable) begin
        if (sb.size() == 0 || sb[0].redir) begin
          checks++; failures++;
          $display("FAIL unexpected_commit at cycle %0d", cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("commit_cycle", cyc, e.cyc);
          chk("rm0", bus.rm0wData, e.rm0);
          chk("rm1", bus.rm1wData, e.rm1);
          chk("rm2", bus.rm2wData, e.rm2);
          chk("rm4", bus.rm4wData, e.rm4);
          chk("commit_stall", {31'd0, bus.stall}, 32'd1);
        end
      end
      if (bus.pcRedirectValid) begin
        if (sb.size() == 0 || !sb[0].redir) begin
          checks++; failures++;
          $display("FAIL unexpected_redirect at cycle %0d", cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("redirect_cycle", cyc, e.cyc);
          chk("pcRedirect", bus.pcRedirect, e.pc);
        end
      end
    end
  end

  // Drive a request in the current cycle N (called just after a posedge);
  // optionally push the hand-computed commit/redirect; returns in cycle N+1.
  task automatic issue(input logic [3:0] exc, input logic iret,
                       input logic [31:0] pc, input logic [31:0] addr,
                       input logic [31:0] priv,
                       input logic [31:0] c0, input logic [31:0] c1, input logic [31:0] c2,
                       input bit expect_it,
                       input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2,
                       input logic [31:0] e4, input logic [31:0] epc);
    int n;
    n = cyc;
    bus.excReq = exc; bus.iretReq = iret; bus.excPc = pc; bus.excAddr = addr;
    bus.curPriv = priv; bus.rmCur0 = c0; bus.rmCur1 = c1; bus.rmCur2 = c2;
    if (expect_it) begin
      sb.push_back('{0, n + 2 + D, e0, e1, e2, e4, 32'd0});
      sb.push_back('{1, n + 3 + D, 32'd0, 32'd0, 32'd0, 32'd0, epc});
    end
    @(posedge clk); #1;
    bus.excReq = 4'b0; bus.iretReq = 1'b0;
  endtask

  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  initial begin
    bus.excReq = 0; bus.iretReq = 0; bus.excPc = 0; bus.excAddr = 0;
    bus.curPriv = 0; bus.rmCur0 = 0; bus.rmCur1 = 0; bus.rmCur2 = 0;

    // Reset state
    step(3);
    @(negedge clk);
    chk("rst_busy",  {31'd0, bus.busy}, 32'd0);
    chk("rst_flush", {31'd0, bus.flush}, 32'd0);
    chk("rst_we",    {31'd0, bus.rmWriteEnable}, 32'd0);
    chk("rst_rm4",   bus.rm4wData, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    step(1);

    // T1: illegal instruction from user mode
    issue(4'b0100, 1'b0, 32'h1010, 32'h0BAD, 32'd0, 0, 0, 0,
          1, 32'h1010, 32'h0BAD, 32'd2, 32'd1, 32'h2000);
    chk("t1_flush", {31'd0, bus.flush}, 32'd1);
    chk("t1_busy",  {31'd0, bus.busy}, 32'd1);
    step(1);
    chk("t1_flush_one_cycle", {31'd0, bus.flush}, 32'd0);
    chk("t1_drain_stall", {31'd0, bus.stall}, 32'd1);
    step(8);
    chk("t1_idle", {31'd0, bus.busy}, 32'd0);

    // T2a: dtlb + interrupt from user mode -> cause 1
    issue(4'b1010, 1'b0, 32'h3000, 32'hDEAD_BEEF, 32'd0, 0, 0, 0,
          1, 32'h3000, 32'hDEAD_BEEF, 32'd1, 32'd1, 32'h2000);
    step(8);
    // T2b: interrupt only while in OS mode -> masked
    issue(4'b1000, 1'b0, 32'h3000, 32'h1234, 32'd1, 0, 0, 0,
          0, 0, 0, 0, 0, 0);
    chk("t2_masked_busy", {31'd0, bus.busy}, 32'd0);
    step(2);
    chk("t2_masked_busy2", {31'd0, bus.busy}, 32'd0);

    // T2c: interrupt alone from user mode is taken, cause 3
    issue(4'b1000, 1'b0, 32'h4444, 32'h5555, 32'd0, 0, 0, 0,
          1, 32'h4444, 32'h5555, 32'd3, 32'd1, 32'h2000);
    step(8);

    // T3: iret from OS mode
    issue(4'b0000, 1'b1, 32'h9999, 32'h8888, 32'd1, 32'h1010, 32'hABCD, 32'd2,
          1, 32'h1010, 32'hABCD, 32'd2, 32'd0, 32'h1010);
    step(8);

    // T4: itlb miss beats simultaneous iret; second request in DRAIN ignored
    issue(4'b0001, 1'b1, 32'h0500, 32'h0600, 32'd1, 32'h7777, 32'h7778, 32'd9,
          1, 32'h0500, 32'h0600, 32'd0, 32'd1, 32'h2000);
    step(1);
    issue(4'b0100, 1'b0, 32'hAAAA, 32'hBBBB, 32'd1, 0, 0, 0,
          0, 0, 0, 0, 0, 0);
    step(8);

    // T5: reset in DRAIN aborts with no commit
    issue(4'b0010, 1'b0, 32'h6000, 32'h6004, 32'd0, 0, 0, 0,
          0, 0, 0, 0, 0, 0);
    step(1);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_busy", {31'd0, bus.busy}, 32'd0);
    chk("t5_stall", {31'd0, bus.stall}, 32'd0);
    chk("t5_rm0", bus.rm0wData, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t5_idle_after", {31'd0, bus.busy}, 32'd0);
    chk("t5_rm1_cleared", bus.rm1wData, 32'd0);
    step(10);

    // T6: back-to-back, second request on first IDLE cycle after REDIRECT
    issue(4'b0100, 1'b0, 32'h1010, 32'h0001, 32'd0, 0, 0, 0,
          1, 32'h1010, 32'h0001, 32'd2, 32'd1, 32'h2000);
    step(3 + D);
    issue(4'b0010, 1'b0, 32'h2020, 32'h0002, 32'd0, 0, 0, 0,
          1, 32'h2020, 32'h0002, 32'd1, 32'd1, 32'h2000);
    step(10);

    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
